// File: rtl/cabac_bin_sequencer.sv
// CABAC bin sequencer: owns the bitstream reservoir, runs the decoder init load
// and steps the arithmetic decoder core once per parser bin request.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no slice active, reservoir idle, every strobe low
// INIT  | refilling until INIT_BITS are buffered, then one init_load
// WAIT  | waiting for a parser request (needs >= 8 buffered bits)
// EXEC  | single cycle: core stepped, bin captured, renorm bits consumed
// RESP  | decoded bin offered to the parser until bin_ready
module cabac_bin_sequencer #(
  parameter int BIN_WIDTH = 1,
  parameter int INIT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 bs_valid,
  output logic                 bs_ready,
  input  logic [31:0]          bs_data,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_bypass,
  input  logic [7:0]           req_pstate,
  output logic                 bin_valid,
  input  logic                 bin_ready,
  output logic [BIN_WIDTH-1:0] bin_data,
  output logic                 dec_step,
  output logic                 dec_bypass,
  output logic [7:0]           dec_pstate,
  input  logic [BIN_WIDTH-1:0] dec_bin,
  input  logic [2:0]           dec_numbits,
  output logic [7:0]           dec_bits,
  output logic                 init_load,
  output logic [INIT_BITS-1:0] init_value
);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_WAIT, S_EXEC, S_RESP} state_t;

  localparam logic [6:0] INIT_CNT = 7'(INIT_BITS);
  localparam logic [4:0] INIT_CONSUME = 5'(INIT_BITS);

  state_t               state_q, state_d;
  logic [63:0]          res_q, res_d, res_shift;
  logic [6:0]           cnt_q, cnt_d, cnt_after;
  logic [4:0]           consume;
  logic                 push;
  logic                 bypass_q, bypass_d;
  logic [7:0]           pstate_q, pstate_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;

  // Next-state, handshakes and the number of reservoir bits consumed this cycle.
  always_comb begin
    state_d   = state_q;
    bs_ready  = 1'b0;
    req_ready = 1'b0;
    bin_valid = 1'b0;
    dec_step  = 1'b0;
    init_load = 1'b0;
    consume   = 5'd0;
    bypass_d  = bypass_q;
    pstate_d  = pstate_q;
    bin_d     = bin_q;

    // A word arriving alongside start would be flushed, so it is not accepted.
    if (state_q != S_IDLE && cnt_q <= 7'd32 && !start) bs_ready = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        if (cnt_q >= INIT_CNT) begin
          init_load = 1'b1;
          consume   = INIT_CONSUME;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        req_ready = (cnt_q >= 7'd8);
        if (req_valid && req_ready) begin
          bypass_d = req_bypass;
          pstate_d = req_pstate;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        dec_step = 1'b1;
        bin_d    = dec_bin;
        consume  = bypass_q ? 5'd1 : {2'b00, dec_numbits};
        state_d  = S_RESP;
      end
      S_RESP: begin
        bin_valid = 1'b1;
        if (bin_ready) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort: never accept a request or load init from a reservoir about to be flushed.
    if (start && state_q != S_IDLE) begin
      req_ready = 1'b0;
      init_load = 1'b0;
      state_d   = S_INIT;
    end
  end

  // Reservoir update: consume from the top, then append the new word right below the survivors.
  always_comb begin
    push      = bs_valid && bs_ready;
    res_shift = res_q << consume;
    cnt_after = cnt_q - {2'b00, consume};
    res_d     = res_shift;
    cnt_d     = cnt_after;
    if (push) begin
      res_d = res_shift | ({bs_data, 32'h0} >> cnt_after);
      cnt_d = cnt_after + 7'd32;
    end
    if (start) begin
      res_d = '0;
      cnt_d = '0;
    end
  end

  // State, reservoir and registered request/bin fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      cnt_q    <= '0;
      bypass_q <= 1'b0;
      pstate_q <= '0;
      bin_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      bypass_q <= bypass_d;
      pstate_q <= pstate_d;
      bin_q    <= bin_d;
    end
  end

  assign dec_bypass = bypass_q;
  assign dec_pstate = pstate_q;
  assign bin_data   = bin_q;
  assign dec_bits   = dec_step ? res_q[63:56] : 8'h00;
  assign init_value = init_load ? res_q[63 -: INIT_BITS] : '0;

endmodule

// File: tb/tb_cabac_bin_sequencer.sv
// Directed bench for cabac_bin_sequencer: a table of bin requests with
// hand-computed reservoir bits, plus hand-written init/stall/abort/reset sequences.
module tb_cabac_bin_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        bs_valid;
  logic        bs_ready;
  logic [31:0] bs_data;
  logic        req_valid;
  logic        req_ready;
  logic        req_bypass;
  logic [7:0]  req_pstate;
  logic        bin_valid;
  logic        bin_ready;
  logic        bin_data;
  logic        dec_step;
  logic        dec_bypass;
  logic [7:0]  dec_pstate;
  logic        dec_bin;
  logic [2:0]  dec_numbits;
  logic [7:0]  dec_bits;
  logic        init_load;
  logic [15:0] init_value;

  int n_err;
  int n_chk;

  typedef struct {
    logic       byp;
    logic [7:0] pst;
    logic [2:0] nb;
    logic       bin;
    logic [7:0] bits;
    int         cnt;
  } vec_t;

  vec_t tbl [12];

  cabac_bin_sequencer #(.BIN_WIDTH(1), .INIT_BITS(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bs_valid   (bs_valid),
    .bs_ready   (bs_ready),
    .bs_data    (bs_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_bypass (req_bypass),
    .req_pstate (req_pstate),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .bin_data   (bin_data),
    .dec_step   (dec_step),
    .dec_bypass (dec_bypass),
    .dec_pstate (dec_pstate),
    .dec_bin    (dec_bin),
    .dec_numbits(dec_numbits),
    .dec_bits   (dec_bits),
    .init_load  (init_load),
    .init_value (init_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    chk($sformatf("%s bs_ready", tag), 32'(bs_ready), 0);
    chk($sformatf("%s req_ready", tag), 32'(req_ready), 0);
    chk($sformatf("%s bin_valid", tag), 32'(bin_valid), 0);
    chk($sformatf("%s dec_step", tag), 32'(dec_step), 0);
    chk($sformatf("%s init_load", tag), 32'(init_load), 0);
    chk($sformatf("%s bin_data", tag), 32'(bin_data), 0);
    chk($sformatf("%s dec_bypass", tag), 32'(dec_bypass), 0);
    chk($sformatf("%s dec_pstate", tag), 32'(dec_pstate), 0);
    chk($sformatf("%s dec_bits", tag), 32'(dec_bits), 0);
    chk($sformatf("%s init_value", tag), 32'(init_value), 0);
  endtask

  // Starts in WAIT; issues one request, plays the core for EXEC, holds bin_ready low for 'hold' cycles.
  task automatic run_bin(input vec_t v, input int hold, input string tag);
    req_valid  = 1'b1;
    req_bypass = v.byp;
    req_pstate = v.pst;
    #1;
    chk($sformatf("%s req_ready", tag), 32'(req_ready), 1);
    tick();
    req_valid   = 1'b0;
    req_bypass  = 1'b0;
    req_pstate  = 8'h00;
    dec_numbits = v.nb;
    dec_bin     = v.bin;
    #1;
    chk($sformatf("%s exec dec_step", tag), 32'(dec_step), 1);
    chk($sformatf("%s exec dec_bypass", tag), 32'(dec_bypass), 32'(v.byp));
    chk($sformatf("%s exec dec_pstate", tag), 32'(dec_pstate), 32'(v.pst));
    chk($sformatf("%s exec dec_bits", tag), 32'(dec_bits), 32'(v.bits));
    chk($sformatf("%s exec bin_valid", tag), 32'(bin_valid), 0);
    tick();
    dec_bin     = ~v.bin;
    dec_numbits = 3'd7;
    for (int k = 0; k < hold; k++) begin
      #1;
      chk($sformatf("%s hold%0d bin_valid", tag, k), 32'(bin_valid), 1);
      chk($sformatf("%s hold%0d bin_data", tag, k), 32'(bin_data), 32'(v.bin));
      chk($sformatf("%s hold%0d req_ready", tag, k), 32'(req_ready), 0);
      chk($sformatf("%s hold%0d dec_step", tag, k), 32'(dec_step), 0);
      tick();
    end
    bin_ready = 1'b1;
    #1;
    chk($sformatf("%s resp bin_valid", tag), 32'(bin_valid), 1);
    chk($sformatf("%s resp bin_data", tag), 32'(bin_data), 32'(v.bin));
    chk($sformatf("%s resp dec_step", tag), 32'(dec_step), 0);
    tick();
    bin_ready = 1'b0;
    #1;
    chk($sformatf("%s after bin_valid", tag), 32'(bin_valid), 0);
    chk($sformatf("%s after req_ready", tag), 32'(req_ready), 32'(v.cnt >= 8));
    chk($sformatf("%s after bs_ready", tag), 32'(bs_ready), 32'(v.cnt <= 32));
  endtask

  initial begin
    // After init the reservoir holds 16 zero bits; entry 3 onward reads the word 0xA5C39F12
    // appended behind 7 leftover zeros: 0000000 10100101 11000011 10011111 00010010.
    tbl[0]  = '{1'b0, 8'h3A, 3'd3, 1'b1, 8'h00, 13};
    tbl[1]  = '{1'b1, 8'h80, 3'd5, 1'b0, 8'h00, 12};
    tbl[2]  = '{1'b0, 8'h20, 3'd5, 1'b1, 8'h00, 7};
    tbl[3]  = '{1'b0, 8'h3C, 3'd0, 1'b1, 8'h01, 39};
    tbl[4]  = '{1'b0, 8'h7F, 3'd7, 1'b0, 8'h01, 32};
    tbl[5]  = '{1'b1, 8'h11, 3'd6, 1'b1, 8'hA5, 31};
    tbl[6]  = '{1'b0, 8'h05, 3'd4, 1'b0, 8'h4B, 27};
    tbl[7]  = '{1'b0, 8'hA0, 3'd7, 1'b1, 8'hB8, 20};
    tbl[8]  = '{1'b1, 8'hFF, 3'd0, 1'b0, 8'h39, 19};
    tbl[9]  = '{1'b0, 8'h42, 3'd5, 1'b1, 8'h73, 14};
    tbl[10] = '{1'b0, 8'h01, 3'd6, 1'b0, 8'h7C, 8};
    tbl[11] = '{1'b1, 8'h99, 3'd0, 1'b1, 8'h12, 7};

    n_err = 0;
    n_chk = 0;
    reset = 1'b1;
    start = 1'b0;
    bs_valid = 1'b0;
    bs_data = 32'h0;
    req_valid = 1'b0;
    req_bypass = 1'b0;
    req_pstate = 8'h00;
    bin_ready = 1'b0;
    dec_bin = 1'b0;
    dec_numbits = 3'd0;

    // Reset and slice init.
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;
    bs_valid = 1'b1;
    bs_data = 32'h8CD1_0000;
    #1;
    chk("idle bs_ready", 32'(bs_ready), 0);
    tick();
    bs_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("init empty bs_ready", 32'(bs_ready), 1);
    chk("init empty init_load", 32'(init_load), 0);
    chk("init empty req_ready", 32'(req_ready), 0);
    bs_valid = 1'b1;
    bs_data = 32'h8CD1_0000;
    tick();
    bs_valid = 1'b0;
    #1;
    chk("init init_load", 32'(init_load), 1);
    chk("init init_value", 32'(init_value), 32'h8CD1);
    tick();
    chk("wait init_load", 32'(init_load), 0);
    chk("wait req_ready", 32'(req_ready), 1);
    chk("wait bs_ready", 32'(bs_ready), 1);

    // Bin table, with the starve/refill sequence once the reservoir drops to 7 bits.
    for (int i = 0; i < 12; i++) begin
      run_bin(tbl[i], 0, $sformatf("vec%0d", i));
      if (i == 2) begin
        for (int k = 0; k < 3; k++) begin
          req_valid = 1'b1;
          #1;
          chk($sformatf("stall%0d req_ready", k), 32'(req_ready), 0);
          chk($sformatf("stall%0d dec_step", k), 32'(dec_step), 0);
          tick();
        end
        req_valid = 1'b0;
        bs_valid = 1'b1;
        bs_data = 32'hA5C3_9F12;
        #1;
        chk("refill bs_ready", 32'(bs_ready), 1);
        tick();
        bs_valid = 1'b0;
        #1;
        chk("refill req_ready", 32'(req_ready), 1);
        chk("refill bs_ready", 32'(bs_ready), 0);
      end
    end

    // Refill from 7 bits, then hold the bin for 5 cycles.
    bs_valid = 1'b1;
    bs_data = 32'hF000_0000;
    #1;
    chk("hold refill bs_ready", 32'(bs_ready), 1);
    tick();
    bs_valid = 1'b0;
    run_bin('{1'b0, 8'h55, 3'd2, 1'b1, 8'h25, 37}, 5, "hold");

    // Start during RESP aborts the slice.
    req_valid = 1'b1;
    req_bypass = 1'b0;
    req_pstate = 8'h66;
    #1;
    chk("abort req_ready", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    dec_numbits = 3'd1;
    dec_bin = 1'b1;
    #1;
    chk("abort dec_step", 32'(dec_step), 1);
    tick();
    #1;
    chk("abort resp bin_valid", 32'(bin_valid), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("abort bin_valid", 32'(bin_valid), 0);
    chk("abort init_load", 32'(init_load), 0);
    chk("abort req_ready", 32'(req_ready), 0);
    chk("abort bs_ready", 32'(bs_ready), 1);
    chk("abort dec_step", 32'(dec_step), 0);
    bs_valid = 1'b1;
    bs_data = 32'h1234_5678;
    tick();
    bs_valid = 1'b0;
    #1;
    chk("reinit init_load", 32'(init_load), 1);
    chk("reinit init_value", 32'(init_value), 32'h1234);
    tick();
    chk("reinit wait init_load", 32'(init_load), 0);
    chk("reinit wait req_ready", 32'(req_ready), 1);
    run_bin('{1'b0, 8'h0D, 3'd0, 1'b1, 8'h56, 16}, 0, "reinit");

    // Reset in the middle of EXEC.
    req_valid = 1'b1;
    req_bypass = 1'b1;
    req_pstate = 8'hC7;
    tick();
    req_valid = 1'b0;
    req_bypass = 1'b0;
    req_pstate = 8'h00;
    dec_bin = 1'b1;
    reset = 1'b1;
    #1;
    chk("midrst dec_bypass", 32'(dec_bypass), 1);
    tick();
    check_idle("midrst");
    reset = 1'b0;

    // Words offered while IDLE are ignored; the next slice sees only its own word.
    bs_valid = 1'b1;
    bs_data = 32'hDEAD_0000;
    #1;
    chk("idle word bs_ready", 32'(bs_ready), 0);
    tick();
    chk("idle word bs_ready2", 32'(bs_ready), 0);
    bs_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    bs_valid = 1'b1;
    bs_data = 32'hBEEF_0000;
    tick();
    bs_valid = 1'b0;
    #1;
    chk("fresh init_load", 32'(init_load), 1);
    chk("fresh init_value", 32'(init_value), 32'hBEEF);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
